traffic_light_ctrl: RTL and testbench

Parametrised two-street intersection controller with pedestrian phase; successor to the fixed one-clock-per-phase sequencer. Each phase holds for a configurable number of `tick` pulses from an external prescaler. Main-street green extends until a side-street or pedestrian request is pending. Requests are latched synchronously, with no asynchronous edges. Sits between the tick prescaler / button debouncers and the lamp drivers.

---
 rtl/traffic_light_pkg.sv | 41 ++++
 rtl/phase_timer.sv | 25 ++
 rtl/traffic_light_ctrl.sv | 112 +++++++++++
 tb/tb_traffic_light_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types for the intersection controller: state encoding, lamp vector
// and the state-to-lamp decode.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    GR  = 3'd0,
    YR  = 3'd1,
    RR1 = 3'd2,
    RG  = 3'd3,
    RY  = 3'd4,
    RR2 = 3'd5,
    PED = 3'd6
  } tl_state_t;

  typedef struct packed {
    logic mg;
    logic my;
    logic mr;
    logic sg;
    logic sy;
    logic sr;
    logic walk;
  } lamps_t;

  // Unknown encodings show all-red so a corrupted register never lights a green.
  function automatic lamps_t lamps_of(tl_state_t s);
    lamps_t l;
    l = '0;
    case (s)
      GR:       begin l.mg = 1'b1; l.sr = 1'b1; end
      YR:       begin l.my = 1'b1; l.sr = 1'b1; end
      RR1, RR2: begin l.mr = 1'b1; l.sr = 1'b1; end
      RG:       begin l.mr = 1'b1; l.sg = 1'b1; end
      RY:       begin l.mr = 1'b1; l.sy = 1'b1; end
      PED:      begin l.mr = 1'b1; l.sr = 1'b1; l.walk = 1'b1; end
      default:  begin l.mr = 1'b1; l.sr = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter measuring phase length in prescaler ticks; stops at zero.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority so a reset or phase change never sees a stale decrement.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-street intersection controller with tick-timed phases, request latches
// and an optional pedestrian phase after the side-street cycle.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int T_GREEN_MAIN = 20,
  parameter int T_GREEN_SIDE = 10,
  parameter int T_YELLOW     = 3,
  parameter int T_ALLRED     = 1,
  parameter int T_WALK       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       side_sense,
  output logic       MG,
  output logic       MY,
  output logic       MR,
  output logic       SG,
  output logic       SY,
  output logic       SR,
  output logic       ped_walk,
  output logic       ped_wait,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] LD_GM = CNT_W'(T_GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] LD_GS = CNT_W'(T_GREEN_SIDE - 1);
  localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_AR = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_W  = CNT_W'(T_WALK - 1);

  tl_state_t        state, next_state, load_state;
  logic             ped_pend, side_pend;
  logic             expire, timer_zero, timer_load;
  logic [CNT_W-1:0] timer_val;
  lamps_t           lamps;

  assign expire = tick && timer_zero;

  always_comb begin
    next_state = state;
    case (state)
      GR:  if (expire && (side_pend || ped_pend || side_sense || ped_req)) next_state = YR;
      YR:  if (expire) next_state = RR1;
      RR1: if (expire) next_state = RG;
      RG:  if (expire) next_state = RY;
      RY:  if (expire) next_state = RR2;
      RR2: if (expire) next_state = (ped_pend || ped_req) ? PED : GR;
      PED: if (expire) next_state = GR;
      default: next_state = GR;
    endcase
  end

  // Reloading on reset as well keeps the timer register free of its own reset.
  always_comb begin
    load_state = reset ? GR : next_state;
    timer_load = reset || (next_state != state);
    timer_val  = LD_GM;
    case (load_state)
      GR:       timer_val = LD_GM;
      YR, RY:   timer_val = LD_Y;
      RR1, RR2: timer_val = LD_AR;
      RG:       timer_val = LD_GS;
      PED:      timer_val = LD_W;
      default:  timer_val = LD_GM;
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (tick),
    .zero     (timer_zero)
  );

  // Clearing on phase entry wins over setting, so a same-cycle request is served.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= GR;
      ped_pend  <= 1'b0;
      side_pend <= 1'b0;
    end else begin
      state <= next_state;
      if ((state != PED) && (next_state == PED)) begin
        ped_pend <= 1'b0;
      end else if (ped_req && (state != PED)) begin
        ped_pend <= 1'b1;
      end
      if ((state != RG) && (next_state == RG)) begin
        side_pend <= 1'b0;
      end else if (side_sense && (state != RG)) begin
        side_pend <= 1'b1;
      end
    end
  end

  assign lamps    = lamps_of(state);
  assign MG       = lamps.mg;
  assign MY       = lamps.my;
  assign MR       = lamps.mr;
  assign SG       = lamps.sg;
  assign SY       = lamps.sy;
  assign SR       = lamps.sr;
  assign ped_walk = lamps.walk;
  assign ped_wait = ped_pend;
  assign state_o  = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a per-cycle vector table plus
// hand-written sequences for long idle, slow ticks and reset mid-phase.
module tb_traffic_light_ctrl;

  logic       clk, reset, tick, ped_req, side_sense;
  logic       MG, MY, MR, SG, SY, SR, ped_walk, ped_wait;
  logic [2:0] state_o;

  int testsRun    = 0;
  int testsFailed = 0;

  localparam logic [2:0] S_GR = 3'd0, S_YR = 3'd1, S_RR1 = 3'd2, S_RG = 3'd3,
                         S_RY = 3'd4, S_RR2 = 3'd5, S_PED = 3'd6;

  typedef struct {
    logic       rst;
    logic       tck;
    logic       ped;
    logic       side;
    logic [2:0] st;
    logic       wt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  logic [2:0] s1Exp [17] = '{0,0,0,1,1,2,3,3,3,4,4,5,0,0,0,0,1};
  logic [2:0] s4Exp [19] = '{0,0,0,1,1,2,3,3,3,4,4,5,6,6,0,0,0,0,1};
  logic       w4Exp [19] = '{1,1,1,1,1,1,1,1,1,1,1,1,0,0,0,1,1,1,1};
  logic [2:0] s6Exp [9]  = '{0,0,1,1,2,3,3,3,4};

  traffic_light_ctrl #(
    .CNT_W(8), .T_GREEN_MAIN(4), .T_GREEN_SIDE(3), .T_YELLOW(2),
    .T_ALLRED(1), .T_WALK(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
    .side_sense(side_sense), .MG(MG), .MY(MY), .MR(MR), .SG(SG), .SY(SY),
    .SR(SR), .ped_walk(ped_walk), .ped_wait(ped_wait), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp order: MG MY MR SG SY SR walk.
  function automatic logic [6:0] lampsFor(input logic [2:0] st);
    case (st)
      3'd0:       return 7'b1000010;
      3'd1:       return 7'b0100010;
      3'd2, 3'd5: return 7'b0010010;
      3'd3:       return 7'b0011000;
      3'd4:       return 7'b0010100;
      3'd6:       return 7'b0010011;
      default:    return 7'b0000000;
    endcase
  endfunction

  task automatic add(input logic r, input logic t, input logic p, input logic s,
                     input logic [2:0] st, input logic wt, input string nm);
    vec_t v;
    v.rst = r; v.tck = t; v.ped = p; v.side = s; v.st = st; v.wt = wt; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic p, input logic s);
    reset = r; tick = t; ped_req = p; side_sense = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [2:0] st, input logic wt);
    logic [10:0] got, exp;
    got = {state_o, MG, MY, MR, SG, SY, SR, ped_walk, ped_wait};
    exp = {st, lampsFor(st), wt};
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state=%0d lamps=%b wait=%b, expected state=%0d lamps=%b wait=%b",
               nm, got[10:8], got[7:1], got[0], exp[10:8], exp[7:1], exp[0]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; ped_req = 1'b0; side_sense = 1'b0;

    // Continuous side demand: full 13-cycle rotation without PED.
    add(1, 0, 0, 0, S_GR, 0, "s1_reset");
    for (int i = 0; i < 17; i++) add(0, 1, 0, 1, s1Exp[i], 0, "s1_cycle");

    // One-cycle ped pulse during RG is served after RR2.
    add(1, 0, 0, 0, S_GR, 0, "s3_reset");
    for (int i = 0; i < 7; i++) add(0, 1, 0, 1, s1Exp[i], 0, "s3_to_rg");
    add(0, 1, 1, 0, S_RG,  1, "s3_ped_pulse");
    add(0, 1, 0, 0, S_RG,  1, "s3_rg_hold");
    add(0, 1, 0, 0, S_RY,  1, "s3_ry0");
    add(0, 1, 0, 0, S_RY,  1, "s3_ry1");
    add(0, 1, 0, 0, S_RR2, 1, "s3_rr2");
    add(0, 1, 0, 0, S_PED, 0, "s3_ped0");
    add(0, 1, 0, 0, S_PED, 0, "s3_ped1");
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, S_GR, 0, "s3_gr_idle");

    // Ped request held through PED: single PED phase, wait returns after it.
    add(1, 0, 0, 0, S_GR, 0, "s4_reset");
    for (int i = 0; i < 19; i++) add(0, 1, 1, 0, s4Exp[i], w4Exp[i], "s4_ped_held");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].tck, vecs[i].ped, vecs[i].side);
      checkOutput(vecs[i].name, vecs[i].st, vecs[i].wt);
    end

    // Long idle: GR holds, then a latched side pulse exits on the next tick.
    applyStimulus(1, 0, 0, 0);
    checkOutput("s2_reset", S_GR, 0);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("s2_idle_gr", S_GR, 0);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("s2_side_latch", S_GR, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("s2_exit_yr", S_YR, 0);

    // Tick every third cycle stretches GR to 12 cycles.
    applyStimulus(1, 0, 0, 0);
    checkOutput("s5_reset", S_GR, 0);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(0, (i % 3) == 0, 0, 1);
      checkOutput("s5_slow_tick", (i < 12) ? S_GR : S_YR, 0);
    end

    // Reset during RY with a pending ped request.
    applyStimulus(1, 0, 0, 0);
    checkOutput("s6_reset", S_GR, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("s6_ped_req", S_GR, 1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("s6_to_ry", s6Exp[i], 1);
    end
    applyStimulus(1, 1, 0, 0);
    checkOutput("s6_reset_in_ry", S_GR, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1);
      checkOutput("s6_full_dwell", S_GR, 0);
    end
    applyStimulus(0, 1, 0, 1);
    checkOutput("s6_exit_yr", S_YR, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
